// File: rtl/alu_sequencer.sv
// Bus command encodings, opcodes and flag bits shared with the ALU, plus the
// sequencer that loads operands, triggers a compute and reads back Y and F.
package alu_seq_pkg;
  localparam logic [3:0] COM_NOP     = 4'd0;
  localparam logic [3:0] COM_LATCHA  = 4'd1;
  localparam logic [3:0] COM_LATCHB  = 4'd2;
  localparam logic [3:0] COM_LATCHOP = 4'd3;
  localparam logic [3:0] COM_LATCHF  = 4'd4;
  localparam logic [3:0] COM_COMPUTE = 4'd5;
  localparam logic [3:0] COM_OUTPUTY = 4'd6;
  localparam logic [3:0] COM_OUTPUTF = 4'd7;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;

  localparam int F_CARRY = 0;
  localparam int F_ZERO  = 1;
endpackage

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WORDSIZE = 16,
  parameter int CMD_W    = 4
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [WORDSIZE-1:0] i_a,
  input  logic [WORDSIZE-1:0] i_b,
  input  logic [3:0]          i_op,
  input  logic [WORDSIZE-1:0] i_flags,
  input  logic                i_use_flags,
  output logic [CMD_W-1:0]    o_command,
  output logic [WORDSIZE-1:0] o_data,
  output logic                o_valid,
  input  logic [WORDSIZE-1:0] i_data,
  input  logic                i_valid,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [WORDSIZE-1:0] o_y,
  output logic [WORDSIZE-1:0] o_f,
  output logic                o_rsp_err
);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, LOAD_OP, LOAD_F, COMPUTE, READ_Y, READ_F, RESP
  } state_t;

  typedef struct packed {
    logic [WORDSIZE-1:0] a;
    logic [WORDSIZE-1:0] b;
    logic [WORDSIZE-1:0] flags;
    logic [3:0]          op;
    logic                use_flags;
  } req_t;

  state_t state;
  req_t   req;

  // Bus outputs are registered: each transition loads the drive values of the
  // state being entered, so the command lines up exactly with the state.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= IDLE;
      req         <= '0;
      o_req_ready <= 1'b1;
      o_command   <= CMD_W'(COM_NOP);
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_y         <= '0;
      o_f         <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_req_valid && o_req_ready) begin
          req         <= '{a: i_a, b: i_b, flags: i_flags, op: i_op, use_flags: i_use_flags};
          o_rsp_err   <= 1'b0;
          o_req_ready <= 1'b0;
          state       <= LOAD_A;
          o_command   <= CMD_W'(COM_LATCHA);
          o_data      <= i_a;
          o_valid     <= 1'b1;
        end
        LOAD_A: begin
          state     <= LOAD_B;
          o_command <= CMD_W'(COM_LATCHB);
          o_data    <= req.b;
          o_valid   <= 1'b1;
        end
        LOAD_B: begin
          state     <= LOAD_OP;
          o_command <= CMD_W'(COM_LATCHOP);
          o_data    <= WORDSIZE'(req.op);
          o_valid   <= 1'b1;
        end
        LOAD_OP: if (req.use_flags) begin
          state     <= LOAD_F;
          o_command <= CMD_W'(COM_LATCHF);
          o_data    <= req.flags;
          o_valid   <= 1'b1;
        end else begin
          state     <= COMPUTE;
          o_command <= CMD_W'(COM_COMPUTE);
          o_data    <= '0;
          o_valid   <= 1'b0;
        end
        LOAD_F: begin
          state     <= COMPUTE;
          o_command <= CMD_W'(COM_COMPUTE);
          o_data    <= '0;
          o_valid   <= 1'b0;
        end
        COMPUTE: begin
          state     <= READ_Y;
          o_command <= CMD_W'(COM_OUTPUTY);
        end
        READ_Y: begin
          o_y       <= i_data;
          if (!i_valid) o_rsp_err <= 1'b1;
          state     <= READ_F;
          o_command <= CMD_W'(COM_OUTPUTF);
        end
        READ_F: begin
          o_f         <= i_data;
          if (!i_valid) o_rsp_err <= 1'b1;
          state       <= RESP;
          o_command   <= CMD_W'(COM_NOP);
          o_rsp_valid <= 1'b1;
        end
        RESP: if (i_rsp_ready) begin
          state       <= IDLE;
          o_rsp_valid <= 1'b0;
          o_req_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_command   <= CMD_W'(COM_NOP);
          o_data      <= '0;
          o_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU on the bus side.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [15:0] i_a = '0, i_b = '0, i_flags = '0;
  logic [3:0]  i_op = '0;
  logic        i_use_flags = 1'b0;
  logic [3:0]  o_command;
  logic [15:0] o_data;
  logic        o_valid;
  logic [15:0] i_data;
  logic        i_valid;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [15:0] o_y, o_f;
  logic        o_rsp_err;

  int n_assert = 0;
  int n_fail   = 0;
  logic bad_y = 1'b0;

  alu_sequencer #(.WORDSIZE(16), .CMD_W(4)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_a(i_a), .i_b(i_b), .i_op(i_op), .i_flags(i_flags), .i_use_flags(i_use_flags),
    .o_command(o_command), .o_data(o_data), .o_valid(o_valid), .i_data(i_data),
    .i_valid(i_valid), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_y(o_y), .o_f(o_f), .o_rsp_err(o_rsp_err)
  );

  always #5 i_Clk = ~i_Clk;

  // ALU model: latches on bus commands, drives read data while OUTPUT* is on the bus.
  logic [15:0] la = '0, lb = '0, lf = '0, ry = '0, rf = '0;
  logic [3:0]  lop = '0;
  always @(posedge i_Clk) begin
    logic [16:0] sum;
    case (o_command)
      COM_LATCHA:  la  <= o_data;
      COM_LATCHB:  lb  <= o_data;
      COM_LATCHOP: lop <= o_data[3:0];
      COM_LATCHF:  lf  <= o_data;
      COM_COMPUTE: begin
        sum = {1'b0, la} + {1'b0, lb} + ((lop == OP_ADC) ? {16'h0, lf[F_CARRY]} : 17'h0);
        ry <= sum[15:0];
        rf <= 16'(sum[16]) << F_CARRY | 16'(sum[15:0] == 16'h0) << F_ZERO;
      end
      default: ;
    endcase
  end
  always_comb begin
    i_data = '0;
    if (o_command == COM_OUTPUTY) i_data = ry;
    if (o_command == COM_OUTPUTF) i_data = rf;
  end
  assign i_valid = !(bad_y && o_command == COM_OUTPUTY);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE and run until o_rsp_valid (bounded).
  task automatic run_req(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                         input logic [15:0] fl, input logic uf, output int lat,
                         output logic [31:0] seq, output logic [15:0] a_s,
                         output logic [15:0] b_s, output logic [15:0] op_s,
                         output logic err0);
    seq = '0; a_s = '0; b_s = '0; op_s = '0;
    i_a = a; i_b = b; i_op = op; i_flags = fl; i_use_flags = uf; i_req_valid = 1'b1;
    @(posedge i_Clk); #1;
    i_req_valid = 1'b0;
    i_a = 16'hDEAD; i_b = 16'hBEEF; i_op = 4'hF; i_flags = 16'hFFFF; i_use_flags = ~uf;
    err0 = o_rsp_err;
    lat = 0;
    while (!o_rsp_valid && lat < 20) begin
      if (o_command != COM_NOP) seq = {seq[27:0], o_command};
      if (o_command == COM_LATCHA)  a_s = o_data;
      if (o_command == COM_LATCHB)  b_s = o_data;
      if (o_command == COM_LATCHOP) op_s = o_data;
      @(posedge i_Clk); #1;
      lat++;
    end
  endtask

  task automatic release_rsp();
    i_rsp_ready = 1'b1;
    @(posedge i_Clk); #1;
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] seq;
    logic [15:0] a_s, b_s, op_s, y_h, f_h;
    logic err0;

    repeat (2) @(posedge i_Clk);
    @(negedge i_Clk) i_Reset = 1'b0;
    @(posedge i_Clk); #1;
    chk("rst_ready", 32'(o_req_ready), 32'd1);
    chk("rst_cmd_valid_data", {o_command, 11'h0, o_valid, o_data}, 32'h0);
    chk("rst_y_f", {o_y, o_f}, 32'h0);
    chk("rst_rsp", {30'h0, o_rsp_valid, o_rsp_err}, 32'h0);

    // ADD 3+4, no flags; operands scrambled after acceptance
    run_req(16'h0003, 16'h0004, OP_ADD, 16'h0, 1'b0, lat, seq, a_s, b_s, op_s, err0);
    chk("add_lat", 32'(lat), 32'd6);
    chk("add_seq", seq, {8'h0, COM_LATCHA, COM_LATCHB, COM_LATCHOP, COM_COMPUTE, COM_OUTPUTY, COM_OUTPUTF});
    chk("add_bus_data", {a_s, b_s}, 32'h0003_0004);
    chk("add_op_data", 32'(op_s), 32'h0);
    chk("add_y_f", {o_y, o_f}, 32'h0007_0000);
    chk("add_err", 32'(o_rsp_err), 32'd0);
    release_rsp();
    chk("add_idle_ready", {30'h0, o_req_ready, o_rsp_valid}, 32'h2);
    chk("idle_hold_y", 32'(o_y), 32'h0007);

    // ADD overflow: 0xFFFF+1 -> zero with carry
    run_req(16'hFFFF, 16'h0001, OP_ADD, 16'h0, 1'b0, lat, seq, a_s, b_s, op_s, err0);
    chk("ovf_y_f", {o_y, o_f}, 32'h0000_0003);
    chk("ovf_err", 32'(o_rsp_err), 32'd0);
    release_rsp();

    // ADC 1+1 with carry preloaded
    run_req(16'h0001, 16'h0001, OP_ADC, 16'h0001, 1'b1, lat, seq, a_s, b_s, op_s, err0);
    chk("adc_lat", 32'(lat), 32'd7);
    chk("adc_seq", seq, {4'h0, COM_LATCHA, COM_LATCHB, COM_LATCHOP, COM_LATCHF, COM_COMPUTE, COM_OUTPUTY, COM_OUTPUTF});
    chk("adc_op_data", 32'(op_s), 32'h1);
    chk("adc_y", 32'(o_y), 32'h0003);
    release_rsp();

    // Backpressure in RESP with a pending request held high
    run_req(16'h1234, 16'h1111, OP_ADD, 16'h0, 1'b0, lat, seq, a_s, b_s, op_s, err0);
    y_h = o_y; f_h = o_f;
    chk("bp_y", 32'(y_h), 32'h2345);
    i_a = 16'h0002; i_b = 16'h0005; i_op = OP_ADD; i_use_flags = 1'b0; i_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_Clk); #1;
      chk("bp_hold", {o_rsp_valid, o_req_ready, o_y, o_f[13:0]}, {1'b1, 1'b0, y_h, f_h[13:0]});
    end
    i_rsp_ready = 1'b1;
    @(posedge i_Clk); #1;
    i_rsp_ready = 1'b0;
    chk("bp_idle", {30'h0, o_req_ready, o_rsp_valid}, 32'h2);
    @(posedge i_Clk); #1;
    i_req_valid = 1'b0;
    chk("bp_accept", 32'(o_command), 32'(COM_LATCHA));
    lat = 0;
    while (!o_rsp_valid && lat < 20) begin @(posedge i_Clk); #1; lat++; end
    chk("bp_second_y", 32'(o_y), 32'h0007);
    release_rsp();

    // Asynchronous reset during LOAD_B
    i_a = 16'h0009; i_b = 16'h0001; i_op = OP_ADD; i_use_flags = 1'b0; i_req_valid = 1'b1;
    @(posedge i_Clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_Clk); #1;
    chk("pre_rst_cmd", 32'(o_command), 32'(COM_LATCHB));
    i_Reset = 1'b1;
    #1;
    chk("rst_mid_cmd", {o_command, 11'h0, o_valid, o_data}, 32'h0);
    @(negedge i_Clk) i_Reset = 1'b0;
    @(posedge i_Clk); #1;
    chk("rst_mid_ready", 32'(o_req_ready), 32'd1);
    chk("rst_mid_y", 32'(o_y), 32'h0);

    // Invalid read during READ_Y, then cleared on the next acceptance
    bad_y = 1'b1;
    run_req(16'h0005, 16'h0006, OP_ADD, 16'h0, 1'b0, lat, seq, a_s, b_s, op_s, err0);
    bad_y = 1'b0;
    chk("err_set", {31'h0, o_rsp_err}, 32'd1);
    chk("err_f", 32'(o_f), 32'h0);
    release_rsp();
    chk("err_held_idle", 32'(o_rsp_err), 32'd1);
    run_req(16'h0005, 16'h0006, OP_ADD, 16'h0, 1'b0, lat, seq, a_s, b_s, op_s, err0);
    chk("err_clear_accept", 32'(err0), 32'd0);
    chk("err_clear_y", {15'h0, o_rsp_err, o_y}, 32'h0000_000B);
    release_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
